// File: rtl/boolean_expr_if.sv
// Port bundle for boolean_expr: operand/result path, sweep control and truth tables.
// in_valid qualifies a/b/c for a single cycle; there is no backpressure, so each
// valid beat produces exactly one out_valid beat on the following cycle.
interface boolean_expr_if;
   logic       a;
   logic       b;
   logic       c;
   logic       in_valid;
   logic       y1;
   logic       y2;
   logic       y3;
   logic       out_valid;
   logic       sweep_start;
   logic       sweep_busy;
   logic       sweep_done;
   logic [7:0] tt_y1;
   logic [7:0] tt_y2;
   logic [7:0] tt_y3;
   logic [1:0] sweep_state;

   modport master (
      output a, b, c, in_valid, sweep_start,
      input  y1, y2, y3, out_valid, sweep_busy, sweep_done,
      input  tt_y1, tt_y2, tt_y3, sweep_state
   );

   modport slave (
      input  a, b, c, in_valid, sweep_start,
      output y1, y2, y3, out_valid, sweep_busy, sweep_done,
      output tt_y1, tt_y2, tt_y3, sweep_state
   );
endinterface

// File: rtl/boolean_expr.sv
// Registered evaluator for three fixed Boolean equations of a/b/c, plus an
// 8-step sweep engine that captures a truth table per equation.
module boolean_expr (
   input logic           clk,
   input logic           rst_n,
   boolean_expr_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SWEEP = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0] state;
   logic [2:0] idx;
   logic [7:0] tt_y1_q;
   logic [7:0] tt_y2_q;
   logic [7:0] tt_y3_q;
   logic       y1_q;
   logic       y2_q;
   logic       y3_q;
   logic       out_valid_q;
   logic [2:0] eval_res;
   logic [2:0] sweep_res;

   // Result order is {y1, y2, y3}.
   function automatic logic [2:0] eval_eq(input logic a, input logic b, input logic c);
      eval_eq = {(a & b) | (~b & c), (a | c) & (~a | b), a ^ b ^ c};
   endfunction

   assign eval_res  = eval_eq(bus.a, bus.b, bus.c);
   assign sweep_res = eval_eq(idx[2], idx[1], idx[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y1_q        <= 1'b0;
         y2_q        <= 1'b0;
         y3_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            y1_q <= eval_res[2];
            y2_q <= eval_res[1];
            y3_q <= eval_res[0];
         end
      end
   end

   // Starts are only honoured in IDLE, so a pulse during SWEEP or DONE is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= 3'd0;
         tt_y1_q <= 8'h00;
         tt_y2_q <= 8'h00;
         tt_y3_q <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.sweep_start) begin
                  state   <= S_SWEEP;
                  idx     <= 3'd0;
                  tt_y1_q <= 8'h00;
                  tt_y2_q <= 8'h00;
                  tt_y3_q <= 8'h00;
               end
            end
            S_SWEEP: begin
               tt_y1_q[idx] <= sweep_res[2];
               tt_y2_q[idx] <= sweep_res[1];
               tt_y3_q[idx] <= sweep_res[0];
               idx          <= idx + 3'd1;
               if (idx == 3'd7) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.y1          = y1_q;
   assign bus.y2          = y2_q;
   assign bus.y3          = y3_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.sweep_busy  = (state == S_SWEEP);
   assign bus.sweep_done  = (state == S_DONE);
   assign bus.tt_y1       = tt_y1_q;
   assign bus.tt_y2       = tt_y2_q;
   assign bus.tt_y3       = tt_y3_q;
   assign bus.sweep_state = state;
endmodule

// File: tb/tb_boolean_expr.sv
// Self-checking bench for boolean_expr: random operands against an equation
// model, sweep timing and truth tables against the published constants.
module tb_boolean_expr;
   localparam logic [7:0] TT_Y1 = 8'hE2;
   localparam logic [7:0] TT_Y2 = 8'hCA;
   localparam logic [7:0] TT_Y3 = 8'h96;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   logic [2:0] exp_q[$];
   logic [2:0] last_y;

   boolean_expr_if bif ();

   boolean_expr dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [2:0] ref_eval(input int idx);
      int a, b, c;
      logic r1, r2, r3;
      a  = (idx >> 2) & 1;
      b  = (idx >> 1) & 1;
      c  = idx & 1;
      r1 = ((a == 1) && (b == 1)) || ((b == 0) && (c == 1));
      r2 = ((a == 1) || (c == 1)) && ((a == 0) || (b == 1));
      r3 = ((a + b + c) % 2) == 1;
      return {r1, r2, r3};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bif.a           = 1'b0;
      bif.b           = 1'b0;
      bif.c           = 1'b0;
      bif.in_valid    = 1'b0;
      bif.sweep_start = 1'b0;
   endtask

   task automatic drive_abc(input int idx, input logic vld);
      bif.a        = idx[2];
      bif.b        = idx[1];
      bif.c        = idx[0];
      bif.in_valid = vld;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [32:0] got;
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive_abc($urandom_range(0, 7), 1'($urandom_range(0, 1)));
         bif.sweep_start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         got = {bif.y1, bif.y2, bif.y3, bif.out_valid, bif.sweep_busy, bif.sweep_done,
                bif.tt_y1, bif.tt_y2, bif.tt_y3, bif.sweep_state};
         n_checks++;
         if (got !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h required 0", got);
         end
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         got = {bif.y1, bif.y2, bif.y3, bif.out_valid, bif.sweep_busy, bif.sweep_done,
                bif.tt_y1, bif.tt_y2, bif.tt_y3, bif.sweep_state};
         n_checks++;
         if (got !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h required 0", got);
         end
      end
      last_y = 3'b000;
   endtask

   task automatic test_exhaustive();
      logic [2:0] exp;
      logic [7:0] t1, t2, t3;
      t1 = TT_Y1;
      t2 = TT_Y2;
      t3 = TT_Y3;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive_abc(i, 1'b1);
         exp_q.push_back(ref_eval(i));
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         n_checks++;
         if ({bif.y1, bif.y2, bif.y3, bif.out_valid} !== {exp, 1'b1}) begin
            n_fail++;
            $display("FAIL exhaustive_model idx=%0d: got y=%b ov=%b required y=%b ov=1",
                     i, {bif.y1, bif.y2, bif.y3}, bif.out_valid, exp);
         end
         n_checks++;
         if ({bif.y1, bif.y2, bif.y3} !== {t1[i], t2[i], t3[i]}) begin
            n_fail++;
            $display("FAIL exhaustive_table idx=%0d: got y=%b required y=%b",
                     i, {bif.y1, bif.y2, bif.y3}, {t1[i], t2[i], t3[i]});
         end
         last_y = exp;
      end
   endtask

   task automatic test_hold();
      @(negedge clk);
      drive_abc(1, 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if ({bif.y1, bif.y2, bif.y3, bif.out_valid} !== 4'b1111) begin
         n_fail++;
         $display("FAIL hold_load: got y=%b ov=%b required y=111 ov=1",
                  {bif.y1, bif.y2, bif.y3}, bif.out_valid);
      end
      last_y = 3'b111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_abc((i == 0) ? 7 : $urandom_range(0, 7), 1'b0);
         @(posedge clk); #1;
         n_checks++;
         if ({bif.y1, bif.y2, bif.y3, bif.out_valid} !== 4'b1110) begin
            n_fail++;
            $display("FAIL hold_keep: got y=%b ov=%b required y=111 ov=0",
                     {bif.y1, bif.y2, bif.y3}, bif.out_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic       vld;
      int         idx;
      logic [2:0] exp;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         vld = (i < 10) ? 1'b1 : 1'($urandom_range(0, 1));
         idx = $urandom_range(0, 7);
         drive_abc(idx, vld);
         if (vld) exp_q.push_back(ref_eval(idx));
         @(posedge clk); #1;
         if (vld) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
            last_y = exp;
         end
         n_checks++;
         if ({bif.y1, bif.y2, bif.y3, bif.out_valid} !== {last_y, vld}) begin
            n_fail++;
            $display("FAIL back_to_back cyc=%0d: got y=%b ov=%b required y=%b ov=%b",
                     i, {bif.y1, bif.y2, bif.y3}, bif.out_valid, last_y, vld);
         end
      end
   endtask

   // k counts clock edges since the edge that sampled the start pulse.
   task automatic test_sweep(input int restart_k, input bit with_eval);
      int         m;
      int         done_cnt;
      int         idx;
      logic       vld;
      logic [7:0] mask;
      done_cnt = 0;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         bif.sweep_start = (k == 0) || (k == restart_k);
         vld = with_eval ? 1'($urandom_range(0, 1)) : 1'b0;
         idx = $urandom_range(0, 7);
         drive_abc(idx, vld);
         if (vld) exp_q.push_back(ref_eval(idx));
         @(posedge clk); #1;
         m    = (k >= 8) ? 255 : ((1 << k) - 1);
         mask = m[7:0];
         if (bif.sweep_done === 1'b1) done_cnt++;
         n_checks++;
         if ({bif.sweep_busy, bif.sweep_done} !== {(k < 8), (k == 8)}) begin
            n_fail++;
            $display("FAIL sweep_timing k=%0d: got busy=%b done=%b required busy=%b done=%b",
                     k, bif.sweep_busy, bif.sweep_done, (k < 8), (k == 8));
         end
         n_checks++;
         if ({bif.tt_y1, bif.tt_y2, bif.tt_y3} !== {TT_Y1 & mask, TT_Y2 & mask, TT_Y3 & mask}) begin
            n_fail++;
            $display("FAIL sweep_tables k=%0d: got %h %h %h required %h %h %h", k,
                     bif.tt_y1, bif.tt_y2, bif.tt_y3, TT_Y1 & mask, TT_Y2 & mask, TT_Y3 & mask);
         end
         if (with_eval) begin
            if (vld) last_y = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
            n_checks++;
            if ({bif.y1, bif.y2, bif.y3, bif.out_valid} !== {last_y, vld}) begin
               n_fail++;
               $display("FAIL sweep_concurrent k=%0d: got y=%b ov=%b required y=%b ov=%b",
                        k, {bif.y1, bif.y2, bif.y3}, bif.out_valid, last_y, vld);
            end
         end
      end
      idle_inputs();
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL sweep_done_count: got %0d required 1", done_cnt);
      end
   endtask

   task automatic test_reset_mid_sweep();
      logic [32:0] got;
      int          done_cnt;
      done_cnt = 0;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         bif.sweep_start = (k == 0);
         @(posedge clk); #1;
      end
      n_checks++;
      if (bif.sweep_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_sweep_busy: got %b required 1", bif.sweep_busy);
      end
      #1;
      rst_n = 1'b0;
      #1;
      got = {bif.y1, bif.y2, bif.y3, bif.out_valid, bif.sweep_busy, bif.sweep_done,
             bif.tt_y1, bif.tt_y2, bif.tt_y3, bif.sweep_state};
      n_checks++;
      if (got !== 33'd0) begin
         n_fail++;
         $display("FAIL mid_sweep_async_reset: got %h required 0", got);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_y = 3'b000;
      exp_q.delete();
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bif.sweep_done === 1'b1) done_cnt++;
         n_checks++;
         if ({bif.sweep_busy, bif.tt_y1, bif.tt_y2, bif.tt_y3} !== 25'd0) begin
            n_fail++;
            $display("FAIL after_abort: got busy=%b tt=%h %h %h required 0",
                     bif.sweep_busy, bif.tt_y1, bif.tt_y2, bif.tt_y3);
         end
      end
      n_checks++;
      if (done_cnt != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      last_y   = 3'b000;
      idle_inputs();
      test_reset();
      test_exhaustive();
      test_hold();
      test_back_to_back();
      test_sweep(-1, 1'b0);
      test_sweep(3, 1'b0);
      test_sweep(9, 1'b1);
      test_reset_mid_sweep();
      test_sweep(-1, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
